// File: rtl/microwire_eeprom_ctrl_if.sv
// Command/response bus between the register layer and the Microwire EEPROM controller.
// The master issues commands; the slave (controller) answers with a one-cycle response pulse.
interface microwire_eeprom_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [15:0]       cmd_data;
    logic              rsp_valid;
    logic [1:0]        rsp_status;
    logic [15:0]       rsp_data;
    logic              busy;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data,
        input  cmd_ready, rsp_valid, rsp_status, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data,
        output cmd_ready, rsp_valid, rsp_status, rsp_data, busy
    );
endinterface

// File: rtl/microwire_eeprom_ctrl.sv
// Microwire controller for x16 93Cxx EEPROMs: serialises one instruction frame,
// optionally shifts in read data, then polls ready/busy after programming operations.
module microwire_eeprom_ctrl #(
    parameter int ADDR_W        = 6,
    parameter int CLK_DIV       = 64,
    parameter int CS_LOW_CYCLES = 16,
    parameter int POLL_TIMEOUT  = 1000000
) (
    input  logic                   clk,
    input  logic                   rst,
    microwire_eeprom_ctrl_if.slave bus,
    output logic                   cs,
    output logic                   sclk,
    output logic                   din,
    input  logic                   dout
);
    localparam int CMD_BITS = 3 + ADDR_W;
    localparam int FRAME_W  = CMD_BITS + 16;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W    = (CS_LOW_CYCLES > 1) ? $clog2(CS_LOW_CYCLES) : 1;
    localparam int POLL_W   = (POLL_TIMEOUT > 1) ? $clog2(POLL_TIMEOUT) : 1;
    localparam int BIT_W    = $clog2(FRAME_W);

    localparam logic [2:0] OP_READ  = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_ERASE = 3'd2;
    localparam logic [2:0] OP_EWEN  = 3'd3;
    localparam logic [2:0] OP_EWDS  = 3'd4;
    localparam logic [2:0] OP_ERAL  = 3'd5;
    localparam logic [2:0] OP_WRAL  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE, S_SHIFT_OUT, S_READ_IN, S_CS_GAP,
        S_POLL, S_POLL_END, S_ILLEGAL, S_DONE
    } state_t;

    state_t              state, state_next;
    logic [DIV_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [POLL_W-1:0]   poll_cnt;
    logic [FRAME_W-1:0]  frame_q, frame_new;
    logic [15:0]         rd_shift, rsp_data_q;
    logic [2:0]          op_q;
    logic [1:0]          status_q, opcode;
    logic [ADDR_W-1:0]   addr_field;
    logic [15:0]         data_field;
    logic                dout_meta, dout_s, rsp_valid_q;
    logic                half_end, bit_end, shift_last, read_last, gap_end, poll_end;
    logic                write_op, poll_op;

    assign half_end   = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign bit_end    = half_end & sclk;
    assign write_op   = (op_q == OP_WRITE) || (op_q == OP_WRAL);
    assign poll_op    = write_op || (op_q == OP_ERASE) || (op_q == OP_ERAL);
    assign shift_last = (bit_cnt == (write_op ? BIT_W'(FRAME_W - 1) : BIT_W'(CMD_BITS - 1)));
    assign read_last  = (bit_cnt == BIT_W'(16));
    assign gap_end    = (gap_cnt == GAP_W'(CS_LOW_CYCLES - 1));
    assign poll_end   = (poll_cnt == POLL_W'(POLL_TIMEOUT - 1));

    // The frame is left-aligned so din is always the MSB of a register shifted in zeros.
    assign din = frame_q[FRAME_W-1];

    assign bus.cmd_ready  = (state == S_IDLE);
    assign bus.busy       = (state != S_IDLE);
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_status = status_q;
    assign bus.rsp_data   = rsp_data_q;

    // Instruction frame assembled from the command fields at acceptance.
    always_comb begin
        opcode     = 2'b00;
        addr_field = bus.cmd_addr;
        data_field = '0;
        case (bus.cmd_op)
            OP_READ:  opcode = 2'b10;
            OP_WRITE: begin
                opcode     = 2'b01;
                data_field = bus.cmd_data;
            end
            OP_ERASE: opcode = 2'b11;
            OP_EWEN:  addr_field = {2'b11, {(ADDR_W-2){1'b0}}};
            OP_EWDS:  addr_field = '0;
            OP_ERAL:  addr_field = {2'b10, {(ADDR_W-2){1'b0}}};
            OP_WRAL:  begin
                addr_field = {2'b01, {(ADDR_W-2){1'b0}}};
                data_field = bus.cmd_data;
            end
            default:  addr_field = '0;
        endcase
    end
    assign frame_new = {1'b1, opcode, addr_field, data_field};

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (bus.cmd_valid) state_next = (bus.cmd_op == OP_RSVD) ? S_ILLEGAL : S_SHIFT_OUT;
            S_SHIFT_OUT: if (bit_end && shift_last) state_next = (op_q == OP_READ) ? S_READ_IN : S_CS_GAP;
            S_READ_IN:   if (bit_end && read_last) state_next = S_CS_GAP;
            S_CS_GAP:    if (gap_end) state_next = poll_op ? S_POLL : S_DONE;
            // Ready is tested first so it wins over a simultaneous timeout.
            S_POLL:      if (dout_s || poll_end) state_next = S_POLL_END;
            S_POLL_END:  if (gap_end) state_next = S_DONE;
            S_ILLEGAL:   state_next = S_DONE;
            S_DONE:      state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Datapath: SCLK divider, frame shifter, read capture, gap/poll counters and response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_meta   <= 1'b0;
            dout_s      <= 1'b0;
            cs          <= 1'b0;
            sclk        <= 1'b0;
            rsp_valid_q <= 1'b0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            poll_cnt    <= '0;
            frame_q     <= '0;
            rd_shift    <= '0;
            rsp_data_q  <= '0;
            op_q        <= '0;
            status_q    <= '0;
        end else begin
            dout_meta   <= dout;
            dout_s      <= dout_meta;
            cs          <= (state_next == S_SHIFT_OUT) || (state_next == S_READ_IN) ||
                           (state_next == S_POLL);
            rsp_valid_q <= (state_next == S_DONE);
            gap_cnt     <= ((state == S_CS_GAP || state == S_POLL_END) && state_next == state) ?
                           gap_cnt + 1'b1 : '0;
            poll_cnt    <= (state == S_POLL && state_next == S_POLL) ? poll_cnt + 1'b1 : '0;

            if (state == S_IDLE && bus.cmd_valid) begin
                op_q    <= bus.cmd_op;
                div_cnt <= '0;
                bit_cnt <= '0;
                sclk    <= 1'b0;
                if (bus.cmd_op == OP_RSVD) begin
                    status_q <= 2'b10;
                end else begin
                    status_q <= 2'b00;
                    frame_q  <= frame_new;
                end
            end else if (state == S_SHIFT_OUT || state == S_READ_IN) begin
                if (half_end) begin
                    div_cnt <= '0;
                    sclk    <= ~sclk;
                    if (sclk) begin
                        frame_q <= {frame_q[FRAME_W-2:0], 1'b0};
                        bit_cnt <= (state_next != state) ? '0 : bit_cnt + 1'b1;
                        // 17 shifts through 16 bits push the leading dummy zero out.
                        if (state == S_READ_IN) rd_shift <= {rd_shift[14:0], dout_s};
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end

            if (state == S_POLL && state_next == S_POLL_END) status_q <= dout_s ? 2'b00 : 2'b01;
            if (state == S_CS_GAP && state_next == S_DONE && op_q == OP_READ) rsp_data_q <= rd_shift;
        end
    end
endmodule

// File: tb/tb_microwire_eeprom_ctrl.sv
// Scoreboarded bench for microwire_eeprom_ctrl with a behavioural 93C46 (x16) model on the pins.
module tb_microwire_eeprom_ctrl;
    localparam int ADDR_W   = 6;
    localparam int CLK_DIV  = 4;
    localparam int CS_LOW   = 16;
    localparam int POLL_TO  = 1000;
    localparam int BUSY_CLK = 300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cs, sclk, din, dout;

    microwire_eeprom_ctrl_if #(.ADDR_W(ADDR_W)) bus();

    microwire_eeprom_ctrl #(
        .ADDR_W(ADDR_W), .CLK_DIV(CLK_DIV), .CS_LOW_CYCLES(CS_LOW), .POLL_TIMEOUT(POLL_TO)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .cs(cs), .sclk(sclk), .din(din), .dout(dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         tag;
        logic [1:0] status;
        logic [15:0] data;
        int         pulses;
        logic [8:0] hdr;
        int         cs_rises;
        int         latency;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Behavioural 93C46 in x16 mode, evaluated on the falling clk edge.
    logic [15:0] mem [64];
    logic [23:0] rx_sh = '0;
    logic [1:0]  m_opc = '0, m_sub = '0;
    logic [5:0]  m_addr = '0;
    logic [15:0] rd_word = '0;
    logic        dout_q = 1'b0;
    bit ewen = 0, reading = 0, prog = 0, stuck0 = 0, m_prev_cs = 0, m_prev_sclk = 0;
    int rx_cnt = 0, rd_idx = 0, busy_cnt = 0;

    assign dout = !cs ? 1'b0 : (reading ? dout_q : (!stuck0 && busy_cnt == 0));

    initial begin
        forever begin
            @(negedge clk);
            if (busy_cnt > 0) busy_cnt--;
            if (cs && sclk && !m_prev_sclk) begin
                if (reading) begin
                    dout_q = (rd_idx == 0) ? 1'b0 : rd_word[16 - rd_idx];
                    rd_idx++;
                end else begin
                    rx_sh = {rx_sh[22:0], din};
                    rx_cnt++;
                    if (rx_cnt == 9) begin
                        m_opc  = rx_sh[7:6];
                        m_addr = rx_sh[5:0];
                        m_sub  = rx_sh[5:4];
                        case (m_opc)
                            2'b10: begin reading = 1; rd_idx = 0; rd_word = mem[m_addr]; end
                            2'b11: if (ewen) begin mem[m_addr] = 16'hFFFF; prog = 1; end
                            2'b00: begin
                                if (m_sub == 2'b11) ewen = 1;
                                else if (m_sub == 2'b00) ewen = 0;
                                else if (m_sub == 2'b10 && ewen) begin
                                    for (int i = 0; i < 64; i++) mem[i] = 16'hFFFF;
                                    prog = 1;
                                end
                            end
                            default: ;
                        endcase
                    end else if (rx_cnt == 25 && ewen) begin
                        if (m_opc == 2'b01) begin
                            mem[m_addr] = rx_sh[15:0];
                            prog = 1;
                        end else if (m_opc == 2'b00 && m_sub == 2'b01) begin
                            for (int i = 0; i < 64; i++) mem[i] = rx_sh[15:0];
                            prog = 1;
                        end
                    end
                end
            end
            if (!cs && m_prev_cs) begin
                rx_cnt  = 0;
                reading = 0;
                if (prog) busy_cnt = BUSY_CLK;
                prog = 0;
            end
            m_prev_cs   = cs;
            m_prev_sclk = sclk;
        end
    end

    // Monitor: tracks bus activity per command and checks each response against the scoreboard.
    int pulses = 0, cs_rises = 0, acc_cyc = 0;
    logic [8:0] hdr = '0;
    bit mon_prev_sclk = 0, mon_prev_cs = 0, ready_chk = 0;
    exp_t mon_e;

    initial begin
        forever begin
            @(negedge clk);
            if (ready_chk) begin
                checkOutput($sformatf("t%0d_cmd_ready_after_rsp", mon_e.tag), bus.cmd_ready, 1);
                ready_chk = 0;
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                pulses   = 0;
                hdr      = '0;
                cs_rises = 0;
                acc_cyc  = cyc;
            end else begin
                if (sclk && !mon_prev_sclk) begin
                    pulses++;
                    if (pulses <= 9) hdr = {hdr[7:0], din};
                end
                if (cs && !mon_prev_cs) cs_rises++;
            end
            mon_prev_sclk = sclk;
            mon_prev_cs   = cs;
            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_rsp: got rsp_valid status %0d, expected no response", bus.rsp_status);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput($sformatf("t%0d_status", mon_e.tag), bus.rsp_status, mon_e.status);
                    checkOutput($sformatf("t%0d_rsp_data", mon_e.tag), bus.rsp_data, mon_e.data);
                    checkOutput($sformatf("t%0d_sclk_pulses", mon_e.tag), pulses, mon_e.pulses);
                    checkOutput($sformatf("t%0d_header_bits", mon_e.tag), hdr, mon_e.hdr);
                    checkOutput($sformatf("t%0d_cs_rises", mon_e.tag), cs_rises, mon_e.cs_rises);
                    checkOutput($sformatf("t%0d_cs_at_rsp", mon_e.tag), cs, 0);
                    if (mon_e.latency >= 0)
                        checkOutput($sformatf("t%0d_latency", mon_e.tag), cyc - acc_cyc, mon_e.latency);
                    ready_chk = 1;
                end
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [5:0] addr, input logic [15:0] data);
        int n = 0;
        @(posedge clk); #1;
        while (!bus.cmd_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.cmd_ready) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL cmd_ready_wait: got cmd_ready 0, expected 1 within 2000 cycles");
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_data  = data;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int tag, input logic [2:0] op, input logic [5:0] addr,
                                 input logic [15:0] data, input logic [1:0] exp_status,
                                 input logic [15:0] exp_data, input int exp_pulses,
                                 input logic [8:0] exp_hdr, input int exp_csr, input int exp_lat);
        exp_t e;
        int n = 0;
        e.tag = tag; e.status = exp_status; e.data = exp_data; e.pulses = exp_pulses;
        e.hdr = exp_hdr; e.cs_rises = exp_csr; e.latency = exp_lat;
        sb.push_back(e);
        issue(op, addr, data);
        while (sb.size() > 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL t%0d_rsp_timeout: got no rsp_valid, expected one within 3000 cycles", tag);
            sb.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int n = 0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        mem[6'h2A] = 16'hBEEF;

        repeat (3) @(posedge clk); #1;
        checkOutput("reset_cs", cs, 0);
        checkOutput("reset_sclk", sclk, 0);
        checkOutput("reset_din", din, 0);
        checkOutput("reset_cmd_ready", bus.cmd_ready, 1);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_rsp_valid", bus.rsp_valid, 0);
        checkOutput("reset_rsp_status", bus.rsp_status, 0);
        checkOutput("reset_rsp_data", bus.rsp_data, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // READ latency 1+26*8+16+1 inclusive; rsp seen 225 cycles after acceptance.
        applyStimulus(1, 3'd0, 6'h2A, 16'h0000, 2'b00, 16'hBEEF, 26, 9'b110101010, 1, 225);
        applyStimulus(2, 3'd3, 6'h00, 16'h0000, 2'b00, 16'hBEEF, 9,  9'b100110000, 1, 89);
        applyStimulus(3, 3'd1, 6'h05, 16'h1234, 2'b00, 16'hBEEF, 25, 9'b101000101, 2, -1);
        applyStimulus(4, 3'd0, 6'h05, 16'h0000, 2'b00, 16'h1234, 26, 9'b110000101, 1, 225);
        // Stuck-busy WRAL: 200 shift + 16 gap + 1000 poll + 16 gap + 1 done.
        stuck0 = 1;
        applyStimulus(5, 3'd6, 6'h00, 16'hA5A5, 2'b01, 16'h1234, 25, 9'b100010000, 2, 1233);
        stuck0 = 0;
        applyStimulus(6, 3'd7, 6'h00, 16'h0000, 2'b10, 16'h1234, 0,  9'b000000000, 0, 2);

        // Abort a WRITE while its 12th bit is on the bus; no response and no programming.
        issue(3'd1, 6'h07, 16'hFFFF);
        @(negedge clk); #1;
        while (!(pulses == 12 && sclk) && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("abort_din_before_rst", din, 1);
        rst = 1'b1;
        #1;
        checkOutput("abort_cs", cs, 0);
        checkOutput("abort_sclk", sclk, 0);
        checkOutput("abort_din", din, 0);
        checkOutput("abort_cmd_ready", bus.cmd_ready, 1);
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);

        applyStimulus(7, 3'd0, 6'h07, 16'h0000, 2'b00, 16'hA5A5, 26, 9'b110000111, 1, 225);
        applyStimulus(8, 3'd2, 6'h07, 16'h0000, 2'b00, 16'hA5A5, 9,  9'b111000111, 2, -1);
        applyStimulus(9, 3'd0, 6'h07, 16'h0000, 2'b00, 16'hFFFF, 26, 9'b110000111, 1, 225);
        applyStimulus(10, 3'd4, 6'h00, 16'h0000, 2'b00, 16'hFFFF, 9, 9'b100000000, 1, 89);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
